dram_4116_ctrl: RTL and testbench

Synchronous initiator for one 16384x1 4116-style DRAM with a multiplexed 7-bit address bus. It converts single-bit read/write requests on a valid/ready interface into RAS_n/CAS_n/WE_n strobe sequences and drives row then column address. Writes are early-write (WE_n low before CAS_n falls). It also issues periodic RAS-only refresh over all 128 rows. It sits between the video/CPU arbitration logic and the behavioural DRAM model.

---
 rtl/dram_4116_pkg.sv | 20 ++
 rtl/dram_4116_ctrl_if.sv | 23 ++
 rtl/dram_4116_ctrl_refresh_timer.sv | 58 +++++
 rtl/dram_4116_ctrl.sv | 157 +++++++++++++++
 tb/tb_dram_4116_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_4116_pkg.sv
// Shared types and address geometry for the 4116 DRAM controller slice.
package dram_4116_pkg;

  localparam int ROW_BITS  = 7;
  localparam int COL_BITS  = 7;
  localparam int ADDR_BITS = ROW_BITS + COL_BITS;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ROW  = 3'd1,
    ST_COL  = 3'd2,
    ST_REF  = 3'd3,
    ST_PRE  = 3'd4
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dram_4116_ctrl_if.sv
// Request/response bus between the arbitration logic (master) and the DRAM controller (slave).
interface dram_4116_ctrl_if;
  import dram_4116_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_BITS-1:0] req_addr;
  logic                 req_wdata;
  logic                 rsp_valid;
  logic                 rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/dram_4116_ctrl_refresh_timer.sv
// Refresh interval down-counter, pending flag and wrapping refresh-row counter.
module dram_refresh_timer
  import dram_4116_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 780
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic                due_o,
  output logic                due_next_o,
  output logic [ROW_BITS-1:0] row_o
);

  localparam int              CNT_W  = $clog2(REFRESH_INTERVAL);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_INTERVAL - 1);

  logic [CNT_W-1:0]    count_q, count_d;
  logic                pending_q, pending_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic                tick_s;

  // A tick consumed by the same edge that enters refresh must not leave the flag set.
  always_comb begin
    tick_s  = (count_q == {CNT_W{1'b0}});
    count_d = tick_s ? RELOAD : (count_q - CNT_W'(1));
    if (clr_i) begin
      pending_d = 1'b0;
    end else if (tick_s) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
    if (inc_i) begin
      row_d = row_q + ROW_BITS'(1);
    end else begin
      row_d = row_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= RELOAD;
      pending_q <= 1'b0;
      row_q     <= {ROW_BITS{1'b0}};
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
      row_q     <= row_d;
    end
  end

  assign due_o      = pending_q | tick_s;
  assign due_next_o = pending_d | (count_d == {CNT_W{1'b0}});
  assign row_o      = row_q;

endmodule

// File: rtl/dram_4116_ctrl.sv
// Single-bit request to 4116 RAS/CAS/WE sequencer with RAS-only refresh; all pins registered.
module dram_4116_ctrl
  import dram_4116_pkg::*;
#(
  parameter int T_RCD            = 2,
  parameter int T_CAS            = 2,
  parameter int T_RP             = 2,
  parameter int REFRESH_INTERVAL = 780
) (
  input  logic                clk,
  input  logic                rst_n,
  dram_4116_ctrl_if.slave     bus,
  output logic                RAS_n,
  output logic                CAS_n,
  output logic                WE_n,
  output logic [ROW_BITS-1:0] A,
  output logic                D,
  input  logic                Q
);

  localparam int PH_MAX = max_int(T_RCD + T_CAS, T_RP);
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] ROW_LAST = PH_W'(T_RCD - 1);
  localparam logic [PH_W-1:0] COL_LAST = PH_W'(T_CAS - 1);
  localparam logic [PH_W-1:0] REF_LAST = PH_W'(T_RCD + T_CAS - 1);
  localparam logic [PH_W-1:0] PRE_LAST = PH_W'(T_RP - 1);

  state_e              state_q;
  logic [PH_W-1:0]     phase_q;
  logic                ras_n_q, cas_n_q, we_n_q, d_q;
  logic [ROW_BITS-1:0] a_q;
  logic [COL_BITS-1:0] col_q;
  logic                is_write_q;
  logic                ready_q, rsp_valid_q, rsp_rdata_q;

  logic                ref_due_s, ref_due_next_s, ref_clr_s, ref_inc_s;
  logic [ROW_BITS-1:0] ref_row_s;

  assign ref_clr_s = (state_q == ST_IDLE) && ref_due_s;
  assign ref_inc_s = (state_q == ST_REF) && (phase_q == REF_LAST);

  dram_refresh_timer #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (ref_clr_s),
    .inc_i      (ref_inc_s),
    .due_o      (ref_due_s),
    .due_next_o (ref_due_next_s),
    .row_o      (ref_row_s)
  );

  // Access/refresh sequencer; ready is computed one cycle ahead so a refresh tick beats a request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= {PH_W{1'b0}};
      ras_n_q     <= 1'b1;
      cas_n_q     <= 1'b1;
      we_n_q      <= 1'b1;
      a_q         <= {ROW_BITS{1'b0}};
      d_q         <= 1'b0;
      col_q       <= {COL_BITS{1'b0}};
      is_write_q  <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ref_due_s) begin
            state_q <= ST_REF;
            phase_q <= {PH_W{1'b0}};
            ras_n_q <= 1'b0;
            a_q     <= ref_row_s;
            ready_q <= 1'b0;
          end else if (bus.req_valid && ready_q) begin
            state_q    <= ST_ROW;
            phase_q    <= {PH_W{1'b0}};
            ras_n_q    <= 1'b0;
            a_q        <= bus.req_addr[ADDR_BITS-1:COL_BITS];
            col_q      <= bus.req_addr[COL_BITS-1:0];
            is_write_q <= bus.req_we;
            we_n_q     <= ~bus.req_we;
            if (bus.req_we) d_q <= bus.req_wdata;
            ready_q    <= 1'b0;
          end else begin
            ready_q <= ~ref_due_next_s;
          end
        end
        ST_ROW: begin
          if (phase_q == ROW_LAST) begin
            state_q <= ST_COL;
            phase_q <= {PH_W{1'b0}};
            a_q     <= col_q;
            cas_n_q <= 1'b0;
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        ST_COL: begin
          if (phase_q == COL_LAST) begin
            state_q <= ST_PRE;
            phase_q <= {PH_W{1'b0}};
            ras_n_q <= 1'b1;
            cas_n_q <= 1'b1;
            we_n_q  <= 1'b1;
            if (!is_write_q) begin
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= Q;
            end
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        ST_REF: begin
          if (phase_q == REF_LAST) begin
            state_q <= ST_PRE;
            phase_q <= {PH_W{1'b0}};
            ras_n_q <= 1'b1;
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        ST_PRE: begin
          if (phase_q == PRE_LAST) begin
            state_q <= ST_IDLE;
            phase_q <= {PH_W{1'b0}};
            ready_q <= ~ref_due_next_s;
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          phase_q <= {PH_W{1'b0}};
          ras_n_q <= 1'b1;
          cas_n_q <= 1'b1;
          we_n_q  <= 1'b1;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign RAS_n         = ras_n_q;
  assign CAS_n         = cas_n_q;
  assign WE_n          = we_n_q;
  assign A             = a_q;
  assign D             = d_q;
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dram_4116_ctrl.sv
// Scoreboard bench for dram_4116_ctrl: directed vectors, behavioural 4116 model and pin checker.
module tb_dram_4116_ctrl;

  localparam int RI       = 64;
  localparam int LAT      = 5;
  localparam int PERIOD   = 7;
  localparam int REF_BUSY = 7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       RAS_n, CAS_n, WE_n, D, Q;
  logic [6:0] A;

  dram_4116_ctrl_if bus();

  dram_4116_ctrl #(
    .T_RCD(2), .T_CAS(2), .T_RP(2), .REFRESH_INTERVAL(RI)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .RAS_n(RAS_n), .CAS_n(CAS_n), .WE_n(WE_n), .A(A), .D(D), .Q(Q)
  );

  always #5 clk = ~clk;

  typedef struct { logic data; int acc_cyc; } exp_t;
  typedef struct { bit we; logic [13:0] addr; bit wd; bit exp; } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        sb_q[$];
  int          acc_count = 0;
  logic [13:0] cur_addr = 14'h0000;
  bit          cur_we = 1'b0;
  bit          cur_wd = 1'b0;
  int          refs = 0;
  bit          chk_spacing = 1'b0;
  int          last_acc_cyc = 0;
  int          last_acc_refs = 0;
  logic        mem [0:16383];

  vec_t vecs [13] = '{
    '{1'b1, 14'h0000, 1'b1, 1'b0},
    '{1'b0, 14'h0000, 1'b0, 1'b1},
    '{1'b1, 14'h2A55, 1'b1, 1'b0},
    '{1'b0, 14'h2A55, 1'b0, 1'b1},
    '{1'b1, 14'h0001, 1'b0, 1'b0},
    '{1'b1, 14'h0000, 1'b0, 1'b0},
    '{1'b0, 14'h0000, 1'b0, 1'b0},
    '{1'b0, 14'h0001, 1'b0, 1'b0},
    '{1'b1, 14'h3FFF, 1'b1, 1'b0},
    '{1'b0, 14'h3FFF, 1'b0, 1'b1},
    '{1'b0, 14'h0080, 1'b0, 1'b0},
    '{1'b1, 14'h0080, 1'b1, 1'b0},
    '{1'b0, 14'h0080, 1'b0, 1'b1}
  };

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural 4116: row latched on RAS fall, column on CAS fall, early write.
  initial begin
    logic       mr_p, mc_p;
    logic [6:0] m_row;
    mr_p = 1'b1; mc_p = 1'b1; m_row = 7'd0; Q = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = 1'b0;
    forever begin
      @(negedge clk);
      if (mr_p && !RAS_n) m_row = A;
      if (mc_p && !CAS_n && !RAS_n) begin
        if (!WE_n) mem[{m_row, A}] = D;
        Q = mem[{m_row, A}];
      end else if (CAS_n) begin
        Q = 1'b0;
      end
      mr_p = RAS_n; mc_p = CAS_n;
    end
  end

  // Scoreboard monitor.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sb_q.delete();
    end else if (bus.rsp_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", int'(bus.rsp_valid), 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rdata", int'(bus.rsp_rdata), int'(e.data));
        chk("read_latency", cyc - e.acc_cyc, LAT);
      end
    end
  end

  // Pin sequence checker: addresses, early write, RAS-only refresh rows and spacing.
  initial begin
    logic       rp, cp, wp, cas_in_ref;
    bit         in_ref, in_acc, last_ok;
    int         acc_seen, last_ref;
    logic [6:0] ref_exp;
    rp = 1'b1; cp = 1'b1; wp = 1'b1; cas_in_ref = 1'b0;
    in_ref = 1'b0; in_acc = 1'b0; last_ok = 1'b0;
    acc_seen = 0; last_ref = 0; ref_exp = 7'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rp = 1'b1; cp = 1'b1; wp = 1'b1;
        in_ref = 1'b0; in_acc = 1'b0; last_ok = 1'b0;
        acc_seen = acc_count; ref_exp = 7'd0;
      end else begin
        if (rp && !RAS_n) begin
          if (acc_seen != acc_count) begin
            acc_seen = acc_count;
            in_acc = 1'b1;
            chk("row_addr", int'(A), int'(cur_addr[13:7]));
            chk("we_with_ras", int'(WE_n), cur_we ? 0 : 1);
            if (cur_we) chk("d_with_ras", int'(D), int'(cur_wd));
          end else begin
            in_ref = 1'b1;
            cas_in_ref = 1'b0;
            chk("ref_row", int'(A), int'(ref_exp));
            ref_exp = ref_exp + 7'd1;
            if (chk_spacing && last_ok) chk("ref_spacing", cyc - last_ref, RI);
            last_ref = cyc;
            last_ok = chk_spacing;
            refs++;
          end
        end
        if (in_ref && !CAS_n) cas_in_ref = 1'b1;
        if (cp && !CAS_n && in_acc) begin
          chk("col_addr", int'(A), int'(cur_addr[6:0]));
          chk("we_before_cas", int'(wp), cur_we ? 0 : 1);
          if (cur_we) chk("d_at_cas", int'(D), int'(cur_wd));
        end
        if (!rp && RAS_n) begin
          if (in_ref) chk("cas_in_ref", int'(cas_in_ref), 0);
          in_ref = 1'b0;
          in_acc = 1'b0;
        end
        rp = RAS_n; cp = CAS_n; wp = WE_n;
      end
    end
  end

  task automatic send(input bit we, input logic [13:0] addr, input bit wd, input bit exp,
                      input bit b2b, output int waited);
    int   n;
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      if (!bus.req_ready) n++;
    end while (!bus.req_ready && n < 200);
    waited = n;
    if (!bus.req_ready) begin
      chk("accept_timeout", n, 0);
      bus.req_valid = 1'b0;
      return;
    end
    cur_addr = addr; cur_we = we; cur_wd = wd;
    acc_count++;
    if (!we) begin
      e.data = exp;
      e.acc_cyc = cyc;
      sb_q.push_back(e);
    end
    if (b2b && refs == last_acc_refs) chk("access_period", cyc - last_acc_cyc, PERIOD);
    last_acc_cyc = cyc;
    last_acc_refs = refs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("drain", sb_q.size(), 0);
  endtask

  initial begin
    int   w, t, r0;
    bit   found;
    logic prev;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 14'h0000; bus.req_wdata = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ras", int'(RAS_n), 1);
    chk("rst_cas", int'(CAS_n), 1);
    chk("rst_we", int'(WE_n), 1);
    chk("rst_a", int'(A), 0);
    chk("rst_d", int'(D), 0);
    chk("rst_ready", int'(bus.req_ready), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_rdata", int'(bus.rsp_rdata), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      send(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].exp, (i > 0), w);
    end
    idle(2);
    drain();

    // Idle bus: 130 refreshes, enough to wrap the refresh row.
    idle(20);
    chk_spacing = 1'b1;
    r0 = refs;
    t = 0;
    while ((refs - r0) < 130 && t < 130 * RI + 500) begin
      @(posedge clk);
      t++;
    end
    chk("idle_ref_count", ((refs - r0) >= 130) ? 1 : 0, 1);
    chk_spacing = 1'b0;

    // Request raised in the cycle the next refresh tick lands.
    found = 1'b0; prev = RAS_n; t = 0;
    while (!found && t < 2 * RI) begin
      @(negedge clk);
      t++;
      if (prev && !RAS_n) found = 1'b1;
      prev = RAS_n;
    end
    chk("ref_seen", int'(found), 1);
    repeat (62) @(negedge clk);
    @(posedge clk);
    #1;
    send(1'b0, 14'h3FFF, 1'b0, 1'b1, 1'b0, w);
    chk("ready_low_for_ref", w, REF_BUSY);
    idle(2);
    drain();

    // Reset during the column phase of a read.
    send(1'b0, 14'h3FFF, 1'b0, 1'b1, 1'b0, w);
    bus.req_valid = 1'b0;
    t = 0;
    while (CAS_n && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("cas_seen", int'(CAS_n), 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ras", int'(RAS_n), 1);
    chk("rst_mid_cas", int'(CAS_n), 1);
    chk("rst_mid_we", int'(WE_n), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", int'(bus.rsp_valid), 0);
    end
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    send(1'b0, 14'h3FFF, 1'b0, 1'b1, 1'b0, w);
    idle(2);
    drain();
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
